bp_fe_itlb_miss_ctrl: RTL
=========================

Name: bp_fe_itlb_miss_ctrl

Overview:
Sequences front-end recovery from an ITLB miss.
- On a fetch miss it captures the faulting PC and stalls PC generation.
- It sends one ITLB-miss exception message toward the BE through the FE queue path.
- It waits for the matching itlb_fill_response command, then issues a single replay of the faulting PC to pc_gen.
- It sits between the ITLB miss outputs, the FE queue mux and the fe_cmd decode logic in the FE top.

Parameters:
- vaddr_width_p, 39, virtual address width.
- page_offset_width_p, 12, page offset bits; vtag width = vaddr_width_p - page_offset_width_p.
- timeout_p, 1024, cycles in WAIT_FILL before the exception is re-sent; must be >= 2.
- cnt_width_p, 16, width of the saturating miss counter.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- itlb_miss_i  in  1  ITLB lookup missed this cycle
- miss_pc_i  in  vaddr_width_p  fetch PC associated with itlb_miss_i
- redirect_v_i  in  1  BE redirect/flush (pc_redirect or state_reset fe_cmd accepted)
- fill_v_i  in  1  itlb_fill_response fe_cmd accepted this cycle
- fill_vtag_i  in  vaddr_width_p-page_offset_width_p  vtag of the fill
- exc_v_o  out  1  exception message valid
- exc_vaddr_o  out  vaddr_width_p  faulting PC carried in the message
- exc_ready_i  in  1  FE queue accepts the exception
- stall_o  out  1  hold pc_gen / block new fetches
- poison_o  out  1  combinational: kill the fetch in flight this cycle
- replay_v_o  out  1  replay request valid
- replay_pc_o  out  vaddr_width_p  PC to refetch
- replay_ready_i  in  1  pc_gen accepts the replay
- miss_count_o  out  cnt_width_p  count of accepted exception handshakes, saturating
- busy_o  out  1  state != READY

Behaviour:
Reset:
- state=READY; latched PC=0; wait counter=0; miss_count_o=0.
- All valid, stall, poison and busy outputs are 0.
- Reset mid-operation aborts any state immediately; no exception or replay is emitted afterwards.

READY:
- stall_o=0.
- If itlb_miss_i & ~redirect_v_i: latch miss_pc_i, poison_o=1 in the same cycle, next state SEND_EXC.
- Redirect has priority over a miss in the same cycle: nothing is captured and poison_o=0.

SEND_EXC:
- exc_v_o=1, exc_vaddr_o=latched PC, stall_o=1.
- exc_v_o stays asserted and exc_vaddr_o stays stable until exc_ready_i.
- On exc_v_o & exc_ready_i: go to WAIT_FILL, clear wait counter, increment miss_count_o (holds at all-ones).
- redirect_v_i: go to READY; no handshake is counted, even if exc_ready_i is high in the same cycle.

WAIT_FILL:
- stall_o=1; wait counter increments each cycle.
- fill_v_i & fill_vtag_i == latched PC[vaddr_width_p-1:page_offset_width_p]: go to REPLAY.
- A fill with a mismatched vtag is ignored; the state is unchanged.
- redirect_v_i: go to READY. Redirect beats a fill in the same cycle.
- Counter reaching timeout_p-1 without a matching fill: go to SEND_EXC and re-send the same vaddr; the counter is cleared.

REPLAY:
- replay_v_o=1, replay_pc_o=latched PC, stall_o=1.
- Hold replay_v_o and replay_pc_o until replay_ready_i, then go to READY.
- redirect_v_i: go to READY with no replay; redirect beats replay_ready_i.

Other rules:
- itlb_miss_i is ignored in every state other than READY; poison_o=0 there.
- poison_o = (state==READY) & itlb_miss_i & ~redirect_v_i.
- A miss may be captured in the cycle right after the REPLAY→READY transition (back-to-back misses are legal).
- exc_v_o and replay_v_o are never asserted together.
- All outputs except poison_o are registered-state decodes.

Test Plan:
- Basic miss: itlb_miss_i=1, miss_pc_i=0x80001234 → poison_o=1 that cycle; exc_v_o=1 with exc_vaddr_o=0x80001234 next cycle; exc_ready_i=1 → miss_count_o=1; fill_v_i with vtag 0x80001 → replay_v_o=1, replay_pc_o=0x80001234; replay_ready_i → busy_o=0.
- Backpressure: exc_ready_i held 0 for 5 cycles → exc_v_o and exc_vaddr_o stable for all 5, miss_count_o stays 0. Same check for replay_ready_i held 0 for 3 cycles.
- Wrong fill: in WAIT_FILL, fill_v_i with vtag 0x90000 → remains in WAIT_FILL, no replay; matching vtag 0x80001 → replay issued.
- Redirect in every state: miss and redirect in the same cycle → no capture, poison_o=0. Redirect during SEND_EXC with exc_ready_i=1 → READY, count unchanged. Redirect alongside a matching fill, and during REPLAY → READY, no replay_v_o.
- Timeout with timeout_p=4: no fill → exc_v_o re-asserted 4 cycles after the first handshake with the same vaddr; miss_count_o=2 after the second accept.
- Reset mid-WAIT_FILL and counter saturation: reset_i pulse → next cycle all outputs 0. With cnt_width_p=2, 5 misses → miss_count_o=3.

Source files
------------

// File: rtl/bp_fe_itlb_miss_ctrl.sv
// ITLB miss recovery sequencer: captures the faulting PC, reports it to the BE,
// waits for the matching fill and then replays the PC into pc_gen.
module bp_fe_itlb_miss_ctrl #(
  parameter int vaddr_width_p       = 39,
  parameter int page_offset_width_p = 12,
  parameter int timeout_p           = 1024,
  parameter int cnt_width_p         = 16
) (
  input  logic                                         clk_i,
  input  logic                                         reset_i,
  input  logic                                         itlb_miss_i,
  input  logic [vaddr_width_p-1:0]                     miss_pc_i,
  input  logic                                         redirect_v_i,
  input  logic                                         fill_v_i,
  input  logic [vaddr_width_p-page_offset_width_p-1:0] fill_vtag_i,
  output logic                                         exc_v_o,
  output logic [vaddr_width_p-1:0]                     exc_vaddr_o,
  input  logic                                         exc_ready_i,
  output logic                                         stall_o,
  output logic                                         poison_o,
  output logic                                         replay_v_o,
  output logic [vaddr_width_p-1:0]                     replay_pc_o,
  input  logic                                         replay_ready_i,
  output logic [cnt_width_p-1:0]                       miss_count_o,
  output logic                                         busy_o
);

  localparam int tw_lp = (timeout_p > 2) ? $clog2(timeout_p) : 1;

  typedef enum logic [1:0] {
    READY     = 2'd0,
    SEND_EXC  = 2'd1,
    WAIT_FILL = 2'd2,
    REPLAY    = 2'd3
  } state_e;

  state_e                   r_state;
  state_e                   w_state_n;
  logic [vaddr_width_p-1:0] r_pc;
  logic [tw_lp-1:0]         r_wait_cnt;
  logic [cnt_width_p-1:0]   r_miss_cnt;
  logic                     r_exc_v;
  logic                     r_replay_v;
  logic                     r_stall;
  logic                     r_busy;

  logic w_capture;
  logic w_exc_hs;
  logic w_fill_match;
  logic w_timeout;

  assign w_capture    = (r_state == READY) & itlb_miss_i & ~redirect_v_i;
  assign w_exc_hs     = (r_state == SEND_EXC) & exc_ready_i & ~redirect_v_i;
  assign w_fill_match = fill_v_i & (fill_vtag_i == r_pc[vaddr_width_p-1:page_offset_width_p]);
  assign w_timeout    = (r_wait_cnt == tw_lp'(timeout_p - 1));

  // Next-state selection; redirect pre-empts every other event.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      READY: begin
        if (w_capture) w_state_n = SEND_EXC;
        else           w_state_n = READY;
      end
      SEND_EXC: begin
        if (redirect_v_i)     w_state_n = READY;
        else if (exc_ready_i) w_state_n = WAIT_FILL;
        else                  w_state_n = SEND_EXC;
      end
      WAIT_FILL: begin
        if (redirect_v_i)      w_state_n = READY;
        else if (w_fill_match) w_state_n = REPLAY;
        else if (w_timeout)    w_state_n = SEND_EXC;
        else                   w_state_n = WAIT_FILL;
      end
      REPLAY: begin
        if (redirect_v_i)        w_state_n = READY;
        else if (replay_ready_i) w_state_n = READY;
        else                     w_state_n = REPLAY;
      end
      default: w_state_n = READY;
    endcase
  end

  // State, captured PC, counters and output flags are decoded from the next state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= READY;
      r_pc       <= '0;
      r_wait_cnt <= '0;
      r_miss_cnt <= '0;
      r_exc_v    <= 1'b0;
      r_replay_v <= 1'b0;
      r_stall    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_exc_v    <= (w_state_n == SEND_EXC);
      r_replay_v <= (w_state_n == REPLAY);
      r_stall    <= (w_state_n != READY);
      r_busy     <= (w_state_n != READY);
      if (w_capture) r_pc <= miss_pc_i;
      // Counter only runs while parked in WAIT_FILL; entry and timeout both restart it.
      if ((r_state == WAIT_FILL) && (w_state_n == WAIT_FILL)) r_wait_cnt <= r_wait_cnt + tw_lp'(1);
      else                                                    r_wait_cnt <= '0;
      if (w_exc_hs && (r_miss_cnt != {cnt_width_p{1'b1}})) r_miss_cnt <= r_miss_cnt + cnt_width_p'(1);
    end
  end

  assign exc_v_o      = r_exc_v;
  assign exc_vaddr_o  = r_pc;
  assign replay_v_o   = r_replay_v;
  assign replay_pc_o  = r_pc;
  assign stall_o      = r_stall;
  assign busy_o       = r_busy;
  assign miss_count_o = r_miss_cnt;
  assign poison_o     = w_capture;

endmodule
